// File: rtl/m31_stream_accumulator_if.sv
// Stream port bundle for the M31 accumulator: element input stream plus packet-sum output.
// The master modport is the producer/consumer side; the slave modport is the accumulator.
interface m31_stream_accumulator_if #(
  parameter int DATA_WIDTH  = 31,
  parameter int COUNT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [COUNT_WIDTH-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/m31_stream_accumulator.sv
// Sums a packetised stream of Mersenne-31 elements, one canonical result per packet.
// Latency: last beat at edge N -> result valid in cycle N+1; one beat per cycle, no bubbles.
// Backpressure: in_ready drops while a result is held and out_ready is low.
module m31_stream_accumulator #(
  parameter int DATA_WIDTH  = 31,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  m31_stream_accumulator_if.slave       s
);

  localparam logic [DATA_WIDTH-1:0]  P       = {DATA_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0]  r_acc;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [COUNT_WIDTH-1:0] r_out_count;

  logic                   w_in_ready;
  logic                   w_accept;
  logic [DATA_WIDTH:0]    w_sum;
  logic [DATA_WIDTH-1:0]  w_fold;
  logic [DATA_WIDTH-1:0]  w_red;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;

  // Ready depends only on reset, clear and the output side, never on the input beat.
  assign w_in_ready = rst_n && !clear && (!r_out_valid || s.out_ready);
  assign w_accept   = s.in_valid && w_in_ready;

  // acc <= p-1 and in_data <= p, so the folded value never exceeds p and one compare finishes it.
  assign w_sum     = {1'b0, r_acc} + {1'b0, s.in_data};
  assign w_fold    = w_sum[DATA_WIDTH-1:0] + {{(DATA_WIDTH-1){1'b0}}, w_sum[DATA_WIDTH]};
  assign w_red     = (w_fold == P) ? '0 : w_fold;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else if (clear) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept && s.in_last) begin
        r_out_data  <= w_red;
        r_out_count <= w_cnt_inc;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_cnt       <= '0;
      end else begin
        if (w_accept) begin
          r_acc <= w_red;
          r_cnt <= w_cnt_inc;
        end
        if (r_out_valid && s.out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign s.in_ready  = w_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_data  = r_out_data;
  assign s.out_count = r_out_count;

endmodule

// File: tb/tb_m31_stream_accumulator.sv
// Directed bench for m31_stream_accumulator: inputs driven on the falling edge, outputs checked there too.
module tb_m31_stream_accumulator;

  logic clk;
  logic rst_n;
  logic clear;
  int   checks;
  int   failures;

  m31_stream_accumulator_if #(.DATA_WIDTH(31), .COUNT_WIDTH(16)) bus ();

  m31_stream_accumulator #(.DATA_WIDTH(31), .COUNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .s     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one beat at a falling edge, wait (bounded) for ready, return at the falling edge after acceptance.
  task automatic send(input logic [30:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("send_ready_timeout", 32'(n), 32'(0));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [30:0] d, input logic [15:0] c);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(1));
    chk({tag, "_data"},  32'(bus.out_data),  32'(d));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data",  32'(bus.out_data),  32'(0));
    chk("rst_out_count", 32'(bus.out_count), 32'(0));
    chk("rst_in_ready",  32'(bus.in_ready),  32'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk);

    // Basic packet and back-to-back single-beat packet
    send(31'd1, 1'b0);
    send(31'd2, 1'b0);
    chk("mid_pkt_out_valid", 32'(bus.out_valid), 32'(0));
    send(31'd3, 1'b1);
    chk_out("basic", 31'd6, 16'd3);
    send(31'd9, 1'b1);
    chk_out("b2b", 31'd9, 16'd1);
    @(negedge clk);
    chk("drain_out_valid", 32'(bus.out_valid), 32'(0));

    // Modular wrap
    send(31'h7FFFFFFE, 1'b0);
    send(31'd2, 1'b1);
    chk_out("wrap_to_1", 31'd1, 16'd2);
    send(31'h7FFFFFFE, 1'b0);
    send(31'd1, 1'b1);
    chk_out("wrap_to_0", 31'd0, 16'd2);
    send(31'h7FFFFFFF, 1'b0);
    send(31'd5, 1'b1);
    chk_out("p_plus_5", 31'd5, 16'd2);
    send(31'h7FFFFFFF, 1'b1);
    chk_out("lone_p", 31'd0, 16'd1);
    @(negedge clk);

    // Backpressure: hold 6 for five cycles with a stalled beat waiting
    bus.out_ready = 1'b0;
    send(31'd1, 1'b0);
    send(31'd2, 1'b0);
    send(31'd3, 1'b1);
    chk_out("bp_first", 31'd6, 16'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 31'd5;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
      @(negedge clk);
    end
    chk_out("bp_held", 31'd6, 16'd3);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("bp_stalled_beat", 31'd5, 16'd1);
    @(negedge clk);
    chk("bp_drain_valid", 32'(bus.out_valid), 32'(0));

    // Clear mid-packet with a beat offered
    send(31'd10, 1'b0);
    send(31'd20, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 31'd99;
    bus.in_last  = 1'b1;
    clear        = 1'b1;
    #1;
    chk("clear_in_ready", 32'(bus.in_ready), 32'(0));
    @(negedge clk);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("clear_no_result", 32'(bus.out_valid), 32'(0));
    send(31'd7, 1'b1);
    chk_out("after_clear", 31'd7, 16'd1);
    @(negedge clk);

    // Clear during HOLD drops the result
    bus.out_ready = 1'b0;
    send(31'd8, 1'b1);
    chk("hold_valid", 32'(bus.out_valid), 32'(1));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_hold_valid", 32'(bus.out_valid), 32'(0));
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("clear_hold_stays", 32'(bus.out_valid), 32'(0));

    // Reset mid-stream
    send(31'd50, 1'b0);
    send(31'd60, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst_out_data",  32'(bus.out_data),  32'(0));
    chk("midrst_out_count", 32'(bus.out_count), 32'(0));
    chk("midrst_in_ready",  32'(bus.in_ready),  32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send(31'd4, 1'b1);
    chk_out("after_rst", 31'd4, 16'd1);
    @(negedge clk);

    // Count saturation: 65536 beats of p-1
    bus.in_valid = 1'b1;
    bus.in_data  = 31'h7FFFFFFE;
    for (int i = 0; i < 65536; i++) begin
      bus.in_last = (i == 65535);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk_out("saturate", 31'h7FFEFFFF, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m31_stream_accumulator.md
# m31_stream_accumulator

Sequential accumulator for the Monolith datapath. It consumes a valid/ready stream of Mersenne-31 field elements (p = 2^31 − 1) grouped into packets by a last flag. It adds each beat into a running sum using the same single-cycle add-and-reduce arithmetic as the M31 adder stage, and emits one canonical sum per packet on a registered, backpressurable output. It sits directly downstream of the M31 adder/reducer lanes and collapses their per-lane results (e.g. MDS row partial sums) into one field element.

## Interface
Parameters:
- DATA_WIDTH, 31, element width. Fixed for M31; other values are unsupported.
- COUNT_WIDTH, 16, width of the per-packet beat counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; discards the partial sum and any held result.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready at a clock edge.
- in_data  in  DATA_WIDTH  element in [0, 2^31−1]; the value p (0x7FFFFFFF) is accepted and treated as 0.
- in_last  in  1  marks the final beat of a packet.
- out_valid  out  1  packet result available.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_data  out  DATA_WIDTH  canonical sum mod p, in [0, p−1].
- out_count  out  COUNT_WIDTH  number of beats in the packet, saturating.

## Operation
- Registers:
  - acc (31 b, always canonical)
  - cnt (COUNT_WIDTH)
  - out_valid, out_data, out_count
- States:
  - ACCUM: out_valid = 0.
  - HOLD: out_valid = 1.
  - The state is encoded by out_valid.
- in_ready is combinational: rst_n && !clear && (!out_valid || out_ready).
  - This allows a new packet's first beat in the same cycle the held result is consumed.
- Reduction applied to each accepted beat:
  - s = acc + in_data (32 b)
  - r = s[30:0] + s[31]
  - if r == p then r = 0
  - The result is always in [0, p−1]. A lone input of p becomes 0.
- Accepted beat with in_last = 0:
  - acc ← r
  - cnt ← sat(cnt + 1)
- Accepted beat with in_last = 1:
  - out_data ← r
  - out_count ← sat(cnt + 1)
  - out_valid ← 1
  - acc ← 0, cnt ← 0
- sat(x) clamps at 2^COUNT_WIDTH − 1. acc keeps wrapping mod p regardless of saturation.
- Output handshake (out_valid && out_ready) with no new last beat accepted in that cycle: out_valid ← 0.
  - out_data and out_count keep their last values; they are don't-care for the consumer.
- Output handshake and a last beat accepted in the same cycle: the new result loads and out_valid stays 1.
- While out_valid && !out_ready, out_data and out_count are held stable and no input is accepted.
- clear = 1:
  - acc ← 0, cnt ← 0, out_valid ← 0.
  - No beat is accepted that cycle.
  - clear has priority over any handshake in the same cycle.
- Zero-length packets do not exist: every packet has at least one beat, the one carrying in_last.

## Timing
- Reset (rst_n low, asynchronous):
  - acc = 0, cnt = 0
  - out_valid = 0, out_data = 0, out_count = 0
  - in_ready = 0 while rst_n is low.
  - Reset mid-packet discards the partial sum. The first edge after deassertion may accept a beat.
- Throughput: one beat per cycle. No bubbles between packets when out_ready = 1.
- Latency: last beat accepted at edge N → out_valid = 1 with the complete sum from edge N (visible in cycle N+1).
- Output ports are registered outputs. in_ready is combinational from out_ready, clear and rst_n only; it has no path from in_valid, in_data or in_last.
- in_data and in_last are sampled only on an accepted beat.

## Test plan
- Reset: assert rst_n = 0 mid-stream → out_valid = 0, out_data = 0, out_count = 0, in_ready = 0. After release, packet {4 last} → out_data = 4, out_count = 1.
- Basic packet: {1, 2, 3 last}, out_ready = 1 → one cycle after the last beat, out_valid = 1, out_data = 6, out_count = 3. A back-to-back packet {9 last} in the next cycle → out_data = 9, with no bubble.
- Modular wrap:
  - {0x7FFFFFFE, 2 last} → 1
  - {0x7FFFFFFE, 1 last} → 0
  - {0x7FFFFFFF, 5 last} → 5
  - {0x7FFFFFFF last} → 0
- Backpressure: result 6 held with out_ready = 0 for 5 cycles → out_data = 6 stable, in_ready = 0, stalled in_valid beats not consumed. Raise out_ready → the stalled first beat is accepted in the same cycle as the output handshake.
- Clear: {10, 20}, then clear = 1 for one cycle while in_valid = 1, then {7 last} → out_data = 7, out_count = 1. Clear during HOLD → out_valid drops next cycle and the result is never delivered.
- Saturation: 65536 beats of 0x7FFFFFFE, last on the final beat → out_count = 0xFFFF, out_data = 0x7FFEFFFF (= −65536 mod p).
